// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// op-class helpers. The MDU_MADD_EN macro enables the multiply-accumulate ops.
package mdu_unit_pkg;

   localparam logic [3:0] MDU_MULT  = 4'd0;
   localparam logic [3:0] MDU_MULTU = 4'd1;
   localparam logic [3:0] MDU_DIV   = 4'd2;
   localparam logic [3:0] MDU_DIVU  = 4'd3;
   localparam logic [3:0] MDU_MTHI  = 4'd4;
   localparam logic [3:0] MDU_MTLO  = 4'd5;
   localparam logic [3:0] MDU_MADD  = 4'd6;
   localparam logic [3:0] MDU_MADDU = 4'd7;
   localparam logic [3:0] MDU_MSUB  = 4'd8;
   localparam logic [3:0] MDU_MSUBU = 4'd9;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_MUL  = 2'd1,
      MDU_DIV_ST = 2'd2
   } mdu_state_e;

   function automatic logic is_mult_class(input logic [3:0] op);
`ifdef MDU_MADD_EN
      return (op == MDU_MULT) || (op == MDU_MULTU) ||
             (op == MDU_MADD) || (op == MDU_MADDU) ||
             (op == MDU_MSUB) || (op == MDU_MSUBU);
`else
      return (op == MDU_MULT) || (op == MDU_MULTU);
`endif
   endfunction

   function automatic logic is_div_class(input logic [3:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_unit_div_core.sv
// Combinational 32-bit divider with sign correction: quotient truncates toward
// zero, remainder takes the dividend's sign. A zero divisor yields don't-care
// results; the caller discards them.
module mdu_unit_div_core (
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic        is_signed,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   logic        neg_n;
   logic        neg_d;
   logic [31:0] mag_n;
   logic [31:0] mag_d;
   logic [31:0] safe_d;
   logic [31:0] q_mag;
   logic [31:0] r_mag;

   // Divide magnitudes unsigned, then restore signs; this makes
   // 0x80000000 / -1 fall out as 0x80000000 without overflow handling.
   always_comb begin
      neg_n     = is_signed & dividend[31];
      neg_d     = is_signed & divisor[31];
      mag_n     = neg_n ? (~dividend + 32'd1) : dividend;
      mag_d     = neg_d ? (~divisor + 32'd1) : divisor;
      safe_d    = (mag_d == 32'd0) ? 32'd1 : mag_d;
      q_mag     = mag_n / safe_d;
      r_mag     = mag_n % safe_d;
      quotient  = (neg_n ^ neg_d) ? (~q_mag + 32'd1) : q_mag;
      remainder = neg_n ? (~r_mag + 32'd1) : r_mag;
   end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Results are computed from the
// operands latched at start and committed when the busy down-counter hits 1.
// Define MDU_MADD_EN to add madd/maddu/msub/msubu.
//
//   state      | meaning
//   MDU_IDLE   | waiting for start; mthi/mtlo write here directly
//   MDU_MUL    | mult-class op counting down MULT_CYCLES
//   MDU_DIV_ST | div-class op counting down DIV_CYCLES
module mdu_unit
   import mdu_unit_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  mdu_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        rd_hi,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDU_OUT
);

   mdu_state_e  state;
   mdu_state_e  state_next;
   logic [15:0] cnt;
   logic [15:0] cnt_next;
   logic        latch_en;
   logic        done;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [3:0]  op_q;
   logic        mul_signed;
   logic [63:0] ext_a;
   logic [63:0] ext_b;
   logic [63:0] prod;
   logic [63:0] mul_result;
   logic [31:0] quo;
   logic [31:0] rem;

   mdu_unit_div_core u_div_core (
      .dividend  (a_q),
      .divisor   (b_q),
      .is_signed (op_q == MDU_DIV),
      .quotient  (quo),
      .remainder (rem)
   );

   // State and countdown register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= MDU_IDLE;
         cnt   <= 16'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state: accept start only in IDLE; finish when the counter reaches 1.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      latch_en   = 1'b0;
      done       = 1'b0;
      case (state)
         MDU_IDLE: begin
            if (start && is_mult_class(mdu_op)) begin
               state_next = MDU_MUL;
               cnt_next   = 16'(MULT_CYCLES);
               latch_en   = 1'b1;
            end else if (start && is_div_class(mdu_op)) begin
               state_next = MDU_DIV_ST;
               cnt_next   = 16'(DIV_CYCLES);
               latch_en   = 1'b1;
            end
         end
         MDU_MUL, MDU_DIV_ST: begin
            if (cnt == 16'd1) begin
               state_next = MDU_IDLE;
               cnt_next   = 16'd0;
               done       = 1'b1;
            end else begin
               cnt_next = cnt - 16'd1;
            end
         end
         default: begin
            state_next = MDU_IDLE;
            cnt_next   = 16'd0;
         end
      endcase
   end

   // 64-bit product of the latched operands, optionally folded into {HI,LO}.
   always_comb begin
      mul_signed = (op_q == MDU_MULT) || (op_q == MDU_MADD) || (op_q == MDU_MSUB);
      ext_a      = mul_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
      ext_b      = mul_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
      prod       = ext_a * ext_b;
      mul_result = prod;
`ifdef MDU_MADD_EN
      case (op_q)
         MDU_MADD, MDU_MADDU: mul_result = {HI, LO} + prod;
         MDU_MSUB, MDU_MSUBU: mul_result = {HI, LO} - prod;
         default:             mul_result = prod;
      endcase
`endif
   end

   // Operand latch and HI/LO writes (direct moves in IDLE, results at completion).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_q  <= 32'd0;
         b_q  <= 32'd0;
         op_q <= 4'd0;
         HI   <= 32'd0;
         LO   <= 32'd0;
      end else begin
         if (latch_en) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= mdu_op;
         end
         if (state == MDU_IDLE && start && mdu_op == MDU_MTHI) begin
            HI <= A;
         end
         if (state == MDU_IDLE && start && mdu_op == MDU_MTLO) begin
            LO <= A;
         end
         if (done) begin
            if (is_div_class(op_q)) begin
               if (b_q != 32'd0) begin
                  HI <= rem;
                  LO <= quo;
               end
            end else begin
               HI <= mul_result[63:32];
               LO <= mul_result[31:0];
            end
         end
      end
   end

   assign busy    = (state != MDU_IDLE);
   assign MDU_OUT = rd_hi ? HI : LO;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed vector table, hand-written
// multi-cycle corner cases and randomized ops against an arithmetic model.
module tb_mdu_unit;
   import mdu_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  mdu_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        rd_hi;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MDU_OUT;

   mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .mdu_op  (mdu_op),
      .A       (A),
      .B       (B),
      .rd_hi   (rd_hi),
      .busy    (busy),
      .HI      (HI),
      .LO      (LO),
      .MDU_OUT (MDU_OUT)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   logic [31:0] m_hi;
   logic [31:0] m_lo;
   int          m_lat;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", name, act, exp);
   endtask

   task automatic check_regs(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      check({tag, " HI"}, HI, exp_hi);
      check({tag, " LO"}, LO, exp_lo);
      rd_hi = 1'b0;
      #1;
      check({tag, " MDU_OUT(lo)"}, MDU_OUT, exp_lo);
      rd_hi = 1'b1;
      #1;
      check({tag, " MDU_OUT(hi)"}, MDU_OUT, exp_hi);
      rd_hi = 1'b0;
   endtask

   // Issue one op, scramble operands after the start edge, count busy cycles.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
      @(negedge clk);
      mdu_op = op;
      A      = a;
      B      = b;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      A     = $urandom;
      B     = $urandom;
      lat   = 0;
      while (busy === 1'b1 && lat < 50) begin
         lat++;
         @(negedge clk);
      end
   endtask

   // Reference model: applies one op to m_hi/m_lo with plain integer arithmetic.
   task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int                sa;
      int                sb;
      longint            sp;
      longint unsigned   up;
      sa = a;
      sb = b;
      sp = longint'(sa) * longint'(sb);
      up = {32'd0, a} * {32'd0, b};
      m_lat = 0;
      case (op)
         MDU_MULT:  begin {m_hi, m_lo} = sp; m_lat = 5; end
         MDU_MULTU: begin {m_hi, m_lo} = up; m_lat = 5; end
         MDU_DIV: begin
            m_lat = 10;
            if (b != 32'd0) begin
               if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                  m_lo = 32'h8000_0000;
                  m_hi = 32'd0;
               end else begin
                  m_lo = sa / sb;
                  m_hi = sa % sb;
               end
            end
         end
         MDU_DIVU: begin
            m_lat = 10;
            if (b != 32'd0) begin
               m_lo = a / b;
               m_hi = a % b;
            end
         end
         MDU_MTHI: m_hi = a;
         MDU_MTLO: m_lo = a;
`ifdef MDU_MADD_EN
         MDU_MADD:  begin {m_hi, m_lo} = {m_hi, m_lo} + sp; m_lat = 5; end
         MDU_MADDU: begin {m_hi, m_lo} = {m_hi, m_lo} + up; m_lat = 5; end
         MDU_MSUB:  begin {m_hi, m_lo} = {m_hi, m_lo} - sp; m_lat = 5; end
         MDU_MSUBU: begin {m_hi, m_lo} = {m_hi, m_lo} - up; m_lat = 5; end
`endif
         default: ;
      endcase
   endtask

   initial begin
      int          lat;
      int          cyc;
      logic [3:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] hold_hi;
      logic [31:0] hold_lo;

      vecs[0]  = '{MDU_MULT,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
      vecs[1]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 5};
      vecs[2]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
      vecs[3]  = '{MDU_DIVU,  32'd7,         32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
      vecs[4]  = '{MDU_MTHI,  32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFD, 0};
      vecs[5]  = '{MDU_MTLO,  32'h9ABC_DEF0, 32'd0,         32'h1234_5678, 32'h9ABC_DEF0, 0};
      vecs[6]  = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
      vecs[7]  = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
      vecs[8]  = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
      vecs[9]  = '{MDU_DIVU,  32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 32'h0FFF_FFFF, 10};
      vecs[10] = '{4'hF,      32'd1,         32'd1,         32'h0000_000F, 32'h0FFF_FFFF, 0};

      reset  = 1'b0;
      start  = 1'b0;
      mdu_op = 4'd0;
      A      = 32'd0;
      B      = 32'd0;
      rd_hi  = 1'b0;
      repeat (2) @(negedge clk);
      check("reset busy", {31'd0, busy}, 32'd0);
      check_regs("reset", 32'd0, 32'd0);
      reset = 1'b1;

      for (int i = 0; i < 11; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
         check_regs($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
      end

      // Start while busy must be ignored: div 100/7 with a mult pulsed mid-run.
      @(negedge clk);
      mdu_op = MDU_DIV;
      A      = 32'd100;
      B      = 32'd7;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 0;
      while (busy === 1'b1 && cyc < 50) begin
         cyc++;
         if (cyc == 2) begin
            mdu_op = MDU_MULT;
            A      = 32'd3;
            B      = 32'd3;
            start  = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("busy-ignore latency", cyc, 10);
      check_regs("busy-ignore", 32'd2, 32'd14);
      repeat (7) @(negedge clk);
      check("busy-ignore no restart", {31'd0, busy}, 32'd0);
      check_regs("busy-ignore hold", 32'd2, 32'd14);

      // Reset in the middle of a division aborts immediately.
      @(negedge clk);
      mdu_op = MDU_DIV;
      A      = 32'd50;
      B      = 32'd3;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("pre-reset busy", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      check("mid-op reset busy", {31'd0, busy}, 32'd0);
      check("mid-op reset HI", HI, 32'd0);
      check("mid-op reset LO", LO, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (12) @(negedge clk);
      check_regs("after abort", 32'd0, 32'd0);

      // Multiply-accumulate encoding: active with the macro, unknown without.
      run_op(MDU_MTLO, 32'hFFFF_FFFF, 32'd0, lat);
      run_op(MDU_MTHI, 32'd0, 32'd0, lat);
      run_op(MDU_MADDU, 32'd1, 32'd1, lat);
`ifdef MDU_MADD_EN
      check("maddu latency", lat, 5);
      check_regs("maddu", 32'd1, 32'd0);
`else
      check("maddu latency", lat, 0);
      check_regs("maddu", 32'd0, 32'hFFFF_FFFF);
`endif

      // Randomized ops against the reference model.
      m_hi = HI === 32'd1 ? 32'd1 : 32'd0;
      m_lo = HI === 32'd1 ? 32'd0 : 32'hFFFF_FFFF;
`ifdef MDU_MADD_EN
      m_hi = 32'd1;
      m_lo = 32'd0;
`else
      m_hi = 32'd0;
      m_lo = 32'hFFFF_FFFF;
`endif
      for (int i = 0; i < 40; i++) begin
`ifdef MDU_MADD_EN
         rop = 4'($urandom_range(0, 10));
`else
         rop = 4'($urandom_range(0, 6));
`endif
         if (rop == 4'd10) rop = 4'hE;
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 9));
            2: ra = 32'($urandom_range(0, 99));
            3: rb = 32'hFFFF_FFFF;
            default: ;
         endcase
         model_apply(rop, ra, rb);
         run_op(rop, ra, rb, lat);
         check($sformatf("rnd%0d op%0d latency", i, rop), lat, m_lat);
         check($sformatf("rnd%0d op%0d HI", i, rop), HI, m_hi);
         check($sformatf("rnd%0d op%0d LO", i, rop), LO, m_lo);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
